// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg
//   Shared definitions for the add/sub sequencer slice: default datapath
//   width, opcode and state encodings, and the opcode legality check.
//   Optional feature macro: ADDSUB_SEQ_ABS_EN (makes opcode 2'b11 = ABS legal).
package addsub_seq_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_NEG = 2'b01,
    OP_SUB = 2'b10,
    OP_ABS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    DONE  = 2'b11
  } state_e;

  // ABS only exists when the optional feature is compiled in; otherwise
  // opcode 2'b11 is reported back as illegal without touching the adder.
  function automatic logic op_is_legal(input op_e op);
`ifdef ADDSUB_SEQ_ABS_EN
    return 1'b1;
`else
    return (op != OP_ABS);
`endif
  endfunction

endpackage

// File: rtl/addsub_sequencer_if.sv
// addsub_sequencer_if
//   Bundles the three channels around the sequencer:
//     request  : req_valid, req_ready, req_op, req_a, req_b
//     response : resp_valid, resp_ready, resp_result, resp_overflow, resp_illegal
//     adder    : add_a, add_b (to the shared adder), add_sum, add_ovf (back)
//   Modports:
//     slave  - the sequencer itself
//     master - the surrounding logic (ALU front-end, consumer, shared adder)
import addsub_seq_pkg::*;

interface addsub_sequencer_if #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_overflow;
  logic             resp_illegal;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, add_sum, add_ovf,
    output req_ready, resp_valid, resp_result, resp_overflow, resp_illegal,
           add_a, add_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, add_sum, add_ovf,
    input  req_ready, resp_valid, resp_result, resp_overflow, resp_illegal,
           add_a, add_b
  );

endinterface

// File: rtl/addsub_operand_mux.sv
// addsub_operand_mux
//   Combinational selection of the shared adder operands from the sequencer
//   state and latched operands.
//   Ports:
//     state, op      - current sequencer state and latched opcode
//     a, b, tmp      - latched operands and the SUB intermediate (-B)
//     add_a, add_b   - operands presented to the shared adder
//   Optional feature macro: ADDSUB_SEQ_ABS_EN (adds the ABS drive in PASS1).
module addsub_operand_mux
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  state_e           state,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] tmp,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Negation is always built as ~x + 1 on the adder. SUB spends PASS1 on
  // negating B and PASS2 on adding A to that; the adder idles at zero in
  // IDLE and DONE so it never toggles without a reason.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      PASS1: begin
        case (op)
          OP_ADD: begin
            add_a = a;
            add_b = b;
          end
          OP_NEG: begin
            add_a = ~a;
            add_b = ONE;
          end
          OP_SUB: begin
            add_a = ~b;
            add_b = ONE;
          end
`ifdef ADDSUB_SEQ_ABS_EN
          OP_ABS: begin
            if (a[WIDTH-1]) begin
              add_a = ~a;
              add_b = ONE;
            end else begin
              add_a = a;
              add_b = '0;
            end
          end
`endif
          default: begin
            add_a = '0;
            add_b = '0;
          end
        endcase
      end
      PASS2: begin
        add_a = a;
        add_b = tmp;
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

endmodule

// File: rtl/addsub_sequencer.sv
// addsub_sequencer
//   Multi-cycle controller that time-shares one external adder between
//   ADD (1 pass), NEG (1 pass, ~A+1), SUB (2 passes: -B then A+(-B)) and,
//   optionally, ABS. Results come back on a valid/ready response channel.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - addsub_sequencer_if.slave: request, response and adder channels
//   Parameters:
//     WIDTH          - datapath width, must match the shared adder (16)
//     ILLEGAL_RESULT - result returned for an unsupported opcode
//   Optional feature macro: ADDSUB_SEQ_ABS_EN (opcode 2'b11 = ABS).
module addsub_sequencer
  import addsub_seq_pkg::*;
#(
  parameter int               WIDTH          = WIDTH_DEF,
  parameter logic [WIDTH-1:0] ILLEGAL_RESULT = '0
) (
  input logic                 clk,
  input logic                 rst,
  addsub_sequencer_if.slave   bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mux_add_a, mux_add_b;

  addsub_operand_mux #(.WIDTH(WIDTH)) u_operand_mux (
    .state (state_q),
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .tmp   (tmp_q),
    .add_a (mux_add_a),
    .add_b (mux_add_b)
  );

  // Next-state and capture logic. Every register holds unless the current
  // state says otherwise, so the response stays frozen in DONE for as long
  // as the consumer applies backpressure. SUB overflow is recomputed from
  // the original operand signs because the adder flag in PASS2 describes
  // A+(-B), which is wrong when B is the most negative value.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tmp_d      = tmp_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d  = bus.req_a;
          b_d  = bus.req_b;
          op_d = op_e'(bus.req_op);
          if (op_is_legal(op_e'(bus.req_op))) begin
            illegal_d = 1'b0;
            state_d   = PASS1;
          end else begin
            result_d   = ILLEGAL_RESULT;
            overflow_d = 1'b0;
            illegal_d  = 1'b1;
            valid_d    = 1'b1;
            state_d    = DONE;
          end
        end
      end
      PASS1: begin
        if (op_q == OP_SUB) begin
          tmp_d   = bus.add_sum;
          state_d = PASS2;
        end else begin
          result_d   = bus.add_sum;
          overflow_d = bus.add_ovf;
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      PASS2: begin
        result_d   = bus.add_sum;
        overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (bus.add_sum[WIDTH-1] != a_q[WIDTH-1]);
        valid_d    = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset abandons any operation in flight
  // without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      tmp_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tmp_q      <= tmp_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.resp_valid    = valid_q;
  assign bus.resp_result   = result_q;
  assign bus.resp_overflow = overflow_q;
  assign bus.resp_illegal  = illegal_q;
  assign bus.add_a         = mux_add_a;
  assign bus.add_b         = mux_add_b;

endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
- Multi-cycle controller that time-shares one external 16-bit ripple adder (A, B, sum, overflow) across ADD, NEG and SUB operations.
- NEG is formed as ~A + 1 on the adder.
- SUB takes two adder passes: pass 1 computes negB = ~B + 1, pass 2 computes A + negB.
- Sits between the ALU front-end (valid/ready request) and the shared adder; returns result and signed overflow on a valid/ready response channel.

Parameters:
- WIDTH, 16, datapath width; must equal the shared adder width (only 16 supported).
- ILLEGAL_RESULT, 16'h0000, result value returned for an unsupported opcode.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept; high only in IDLE.
- req_op  input  2  00 ADD, 01 NEG, 10 SUB, 11 ABS (only with the optional feature; otherwise illegal).
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B; ignored for NEG and ABS.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_result  output  WIDTH  result.
- resp_overflow  output  1  signed overflow of the whole operation.
- resp_illegal  output  1  opcode was unsupported.
- add_a  output  WIDTH  shared adder operand A.
- add_b  output  WIDTH  shared adder operand B.
- add_sum  input  WIDTH  shared adder sum (combinational, same cycle).
- add_ovf  input  1  shared adder signed-overflow flag.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset forces state IDLE and clears a_q, b_q, op_q, tmp_q, resp_result, resp_overflow, resp_illegal and resp_valid to 0, effective the next edge.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - req_ready=1. On req_valid at an edge, latch a_q, b_q, op_q.
  - Legal op goes to PASS1. Illegal op goes to DONE with result=ILLEGAL_RESULT, overflow=0, illegal=1.
- PASS1 adder drive (add_a/add_b are 0 in IDLE/DONE):
  - ADD: add_a=a_q, add_b=b_q.
  - NEG: add_a=~a_q, add_b=1.
  - SUB: add_a=~b_q, add_b=1.
- PASS1 capture at the edge:
  - ADD/NEG: resp_result=add_sum, resp_overflow=add_ovf, then DONE.
  - SUB: tmp_q=add_sum, then PASS2.
- PASS2 (SUB only): add_a=a_q, add_b=tmp_q.
  - Capture resp_result=add_sum, then DONE.
  - resp_overflow=(a_q[15]!=b_q[15]) && (add_sum[15]!=a_q[15]). This is derived from the original operands, NOT from add_ovf, so B=16'h8000 is handled correctly.
- DONE:
  - resp_valid=1; result, overflow and illegal flags are held stable.
  - On resp_ready, go to IDLE and deassert resp_valid next cycle.
  - Backpressure holds DONE indefinitely.
- Latency (accept edge to first resp_valid cycle): ADD/NEG 2 cycles, SUB 3 cycles, illegal 1 cycle. No overlap; the next request is accepted at least one cycle after the response handshake.
- NEG overflow only for A=16'h8000 (result 16'h8000). NEG of 0 gives 0, overflow 0.
- Reset asserted in any state aborts the operation with no response; req_ready=1 the cycle after reset deasserts.
- Inputs changing while not in IDLE are ignored.

Optional Feature:
- Macro: ADDSUB_SEQ_ABS_EN.
- Defined: op 11 = ABS.
  - PASS1 uses NEG drive if a_q[15]=1, else add_a=a_q, add_b=0. Capture is the same as NEG, then DONE.
  - Overflow only for 16'h8000.
- Undefined: op 11 is illegal (resp_illegal=1, ILLEGAL_RESULT, 1-cycle latency).

Decomposition:
- Package addsub_seq_pkg holds:
  - WIDTH_DEF=16.
  - Opcode constants OP_ADD, OP_NEG, OP_SUB, OP_ABS.
  - 2-bit state encoding IDLE/PASS1/PASS2/DONE.
- One natural sub-module, addsub_operand_mux: combinational select of add_a/add_b from state, op_q, a_q, b_q and tmp_q. FSM and capture registers stay in the top.
- The adder itself is instantiated outside, by the parent.

Test Plan:
- ADD 16'h0003+16'h0004 -> resp_result=16'h0007, overflow=0, resp_valid 2 cycles after accept.
- NEG 16'h8000 -> 16'h8000, overflow=1. NEG 16'h0000 -> 16'h0000, overflow=0. NEG 16'h0001 -> 16'hFFFF, overflow=0.
- SUB 16'h0000-16'h8000 -> 16'h8000, overflow=1. SUB 16'h0005-16'h0007 -> 16'hFFFE, overflow=0; resp_valid 3 cycles after accept, PASS2 shows add_b=16'hFFF9.
- Backpressure: hold resp_ready=0 for 5 cycles after ADD 16'h7FFF+1 -> result 16'h8000 / overflow=1 held stable, req_ready=0 throughout, req_valid ignored.
- Op 11 with A=16'hFFFB: ABS_EN defined -> 16'h0005, overflow=0. Undefined -> resp_illegal=1, result 16'h0000, 1-cycle latency.
- rst pulsed during PASS2 of a SUB -> no resp_valid, state IDLE, all outputs 0, next ADD completes correctly.
